led_io_ctrl: RTL and testbench

- Memory-mapped I/O controller between the CPU data port, data_mem and the LED8 peripheral.
- Decodes CPU data accesses and routes them to RAM or to the LED registers.
- Buffers CPU writes to the LED data register in a small FIFO, so back-to-back stores are not lost while LED8 is busy.
- Sequences LED8 with a begin-pulse / busy-wait state machine and exposes a status word the CPU can read.

---
 rtl/led_io_pkg.sv | 46 ++++
 rtl/led_io_ctrl_if.sv | 29 ++
 rtl/led_wr_fifo.sv | 56 +++++
 rtl/led_io_ctrl.sv | 127 ++++++++++++
 tb/tb_led_io_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_io_pkg.sv
`default_nettype none
//==============================================================================
// led_io_pkg : shared constants, FSM encoding and status layout for led_io_ctrl
// Rev 1.0
//==============================================================================
package led_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } led_fsm_e;

  localparam logic [31:0] LED_DATA_ADDR_DEF = 32'h0000_03fc;
  localparam logic [31:0] LED_STAT_ADDR_DEF = 32'h0000_03f8;

  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_EMPTY_BIT    = 1;
  localparam int STAT_FULL_BIT     = 2;
  localparam int STAT_OVF_BIT      = 3;
  localparam int STAT_CNT_LSB      = 4;
  localparam int STAT_CNT_W        = 4;
  localparam int STAT_LED_BUSY_BIT = 8;

  function automatic logic [31:0] pack_status(
    input logic                  busy,
    input logic                  empty,
    input logic                  full,
    input logic                  ovf,
    input logic [STAT_CNT_W-1:0] cnt,
    input logic                  led_busy
  );
    logic [31:0] s;
    s                                = '0;
    s[STAT_BUSY_BIT]                 = busy;
    s[STAT_EMPTY_BIT]                = empty;
    s[STAT_FULL_BIT]                 = full;
    s[STAT_OVF_BIT]                  = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W]    = cnt;
    s[STAT_LED_BUSY_BIT]             = led_busy;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_io_ctrl_if.sv
`default_nettype none
//==============================================================================
// led_io_ctrl_if : CPU data port, data_mem and LED8 signals of led_io_ctrl
// Rev 1.0
//==============================================================================
interface led_io_ctrl_if;

  logic [31:0] dmem_rw_addr;
  logic [31:0] dmem_w_data;
  logic        dmem_w_en;
  logic [31:0] cpu_r_data;
  logic        mem_w_en;
  logic [31:0] mem_r_data;
  logic [31:0] led_in_data;
  logic        led_begin_flag;
  logic [31:0] led_state;

  modport master (
    output dmem_rw_addr, dmem_w_data, dmem_w_en, mem_r_data, led_state,
    input  cpu_r_data, mem_w_en, led_in_data, led_begin_flag
  );

  modport slave (
    input  dmem_rw_addr, dmem_w_data, dmem_w_en, mem_r_data, led_state,
    output cpu_r_data, mem_w_en, led_in_data, led_begin_flag
  );

endinterface
`default_nettype wire

// File: rtl/led_wr_fifo.sv
`default_nettype none
//==============================================================================
// led_wr_fifo : synchronous FIFO buffering CPU stores to the LED data register
// Rev 1.0
//==============================================================================
module led_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/led_io_ctrl.sv
`default_nettype none
//==============================================================================
// led_io_ctrl : CPU address decode, LED write FIFO and LED8 begin/busy sequencer
// Rev 1.0
//==============================================================================
module led_io_ctrl
  import led_io_pkg::*;
#(
  parameter logic [31:0] LED_DATA_ADDR = LED_DATA_ADDR_DEF,
  parameter logic [31:0] LED_STAT_ADDR = LED_STAT_ADDR_DEF,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          START_TIMEOUT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  led_io_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(START_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE       = ST_IDLE;
  localparam logic [1:0] S_ISSUE      = ST_ISSUE;
  localparam logic [1:0] S_WAIT_START = ST_WAIT_START;
  localparam logic [1:0] S_WAIT_DONE  = ST_WAIT_DONE;

  logic             w_hit_data;
  logic             w_hit_stat;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_head;
  logic [31:0]      w_status;
  logic             w_led_busy;
  logic             unused_led_state;

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      led_data_q;
  logic             begin_q;
  logic             ovf_q;

  assign w_hit_data       = (bus.dmem_rw_addr == LED_DATA_ADDR);
  assign w_hit_stat       = (bus.dmem_rw_addr == LED_STAT_ADDR);
  assign w_led_busy       = bus.led_state[0];
  assign unused_led_state = ^bus.led_state[31:1];

  // A store that finds the FIFO full is still taken when the sequencer pops the same edge.
  assign w_push    = bus.dmem_w_en & w_hit_data & (~w_full | w_pop);
  assign w_ovf_set = bus.dmem_w_en & w_hit_data & w_full & ~w_pop;
  assign w_ovf_clr = bus.dmem_w_en & w_hit_stat;

  led_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (bus.dmem_w_data),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TMO_LOAD;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // No busy within the window: LED either finished already or ignored us; no retry.
        if (w_led_busy)          state_d = S_WAIT_DONE;
        else if (tmo_q == '0)    state_d = S_IDLE;
        else                     tmo_d   = tmo_q - TMO_W'(1);
      end
      S_WAIT_DONE: begin
        if (!w_led_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      led_data_q <= '0;
      begin_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      begin_q <= (state_d == S_ISSUE);
      if (w_pop) led_data_q <= w_head;
      if (w_ovf_set)      ovf_q <= 1'b1;
      else if (w_ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign w_status = pack_status((state_q != S_IDLE), w_empty, w_full, ovf_q,
                                STAT_CNT_W'(w_count), w_led_busy);

  assign bus.mem_w_en       = bus.dmem_w_en & ~w_hit_data & ~w_hit_stat;
  assign bus.cpu_r_data     = w_hit_stat ? w_status : bus.mem_r_data;
  assign bus.led_in_data    = led_data_q;
  assign bus.led_begin_flag = begin_q;

endmodule
`default_nettype wire

// File: tb/tb_led_io_ctrl.sv
`default_nettype none
//==============================================================================
// tb_led_io_ctrl : randomized scoreboard bench for led_io_ctrl with an LED8 model
// Rev 1.0
//==============================================================================
module tb_led_io_ctrl;

  localparam int          DEPTH    = 4;
  localparam int          TMO      = 4;
  localparam logic [31:0] DADDR    = 32'h0000_03fc;
  localparam logic [31:0] SADDR    = 32'h0000_03f8;
  localparam logic [31:0] RAM_ADDR = 32'h0000_0100;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic [31:0] mem_data   = '0;
  logic        led_ovr_en = 1'b1;
  logic [31:0] led_ovr    = '0;
  logic        led_busy   = 1'b0;

  led_io_ctrl_if bus();

  assign bus.mem_r_data = mem_data;
  assign bus.led_state  = led_ovr_en ? led_ovr : {31'h0, led_busy};

  led_io_ctrl #(
    .LED_DATA_ADDR (DADDR),
    .LED_STAT_ADDR (SADDR),
    .FIFO_DEPTH    (DEPTH),
    .START_TIMEOUT (TMO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // LED8 model: busy for led_hold cycles after seeing a begin pulse; led_hold = 0 never goes busy.
  int led_hold = 10;
  int led_left = 0;
  always @(negedge clock) begin
    if (led_busy) begin
      led_left--;
      if (led_left <= 0) led_busy = 1'b0;
    end else if (bus.led_begin_flag && led_hold > 0) begin
      led_busy = 1'b1;
      led_left = led_hold;
    end
  end

  logic [31:0] exp_q[$];
  int          begin_cyc[$];
  int          n_begin    = 0;
  logic        prev_begin = 1'b0;

  always @(negedge clock) begin
    if (bus.led_begin_flag) begin
      n_begin++;
      begin_cyc.push_back(cyc);
      n_chk++;
      if (prev_begin) begin
        n_fail++;
        $display("FAIL begin_width: begin high %0d consecutive cycles, required 1", 2);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL begin_unexpected: pulse with data %h, required no pulse", bus.led_in_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.led_in_data !== e) begin
          n_fail++;
          $display("FAIL begin_data: led_in_data %h, required %h", bus.led_in_data, e);
        end
      end
    end
    prev_begin = bus.led_begin_flag;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input bit busy, input int cnt, input bit ovf, input bit ledb);
    int v;
    v = int'(busy) + 2 * int'(cnt == 0) + 4 * int'(cnt == DEPTH) + 8 * int'(ovf)
        + 16 * cnt + 256 * int'(ledb);
    return 32'(v);
  endfunction

  int last_store_cyc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.dmem_rw_addr = a;
    bus.dmem_w_data  = d;
    bus.dmem_w_en    = 1'b1;
    last_store_cyc   = cyc;
  endtask

  task automatic idle_bus();
    @(negedge clock);
    bus.dmem_w_en    = 1'b0;
    bus.dmem_rw_addr = '0;
  endtask

  task automatic read_stat(input string name, input bit busy, input int cnt, input bit ovf);
    @(negedge clock);
    bus.dmem_rw_addr = SADDR;
    bus.dmem_w_en    = 1'b0;
    #1;
    check(name, bus.cpu_r_data, stat_exp(busy, cnt, ovf, led_busy));
  endtask

  task automatic wait_begins(input int target, input int budget);
    int k;
    k = 0;
    while (n_begin < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (n_begin < target) begin
      n_fail++;
      $display("FAIL begin_wait: saw %0d pulses, required %0d", n_begin, target);
    end
  endtask

  task automatic wait_led_idle(input int budget);
    int k;
    k = 0;
    while (led_busy && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("led_idle_wait", {31'h0, led_busy}, 32'h0);
  endtask

  // Model FIFO while the sequencer is stalled on a busy LED: accept up to DEPTH, else overflow.
  task automatic model_push(input logic [31:0] d);
    if (m_cnt < DEPTH) begin
      m_cnt++;
      exp_q.push_back(d);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic overflow_round(input int n, input bit fixed);
    int          base;
    logic [31:0] x;
    led_hold = 40;
    base     = n_begin;
    x        = $urandom;
    exp_q.push_back(x);
    store(DADDR, x);
    idle_bus();
    wait_begins(base + 1, 10);
    repeat (3) @(negedge clock);
    m_cnt = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = fixed ? 32'(i + 1) : $urandom;
      model_push(d);
      store(DADDR, d);
    end
    read_stat("stat_after_burst", 1'b1, m_cnt, m_ovf);
    store(SADDR, $urandom);
    m_ovf = 1'b0;
    read_stat("stat_after_ovf_clear", 1'b1, m_cnt, m_ovf);
    led_hold = 3;
    wait_begins(base + 1 + m_cnt, 400);
    repeat (30) @(negedge clock);
    check("burst_pulse_count", 32'(n_begin), 32'(base + 1 + m_cnt));
    check("burst_queue_drained", 32'(exp_q.size()), 32'h0);
    read_stat("stat_after_drain", 1'b0, 0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    bus.dmem_rw_addr = '0;
    bus.dmem_w_data  = '0;
    bus.dmem_w_en    = 1'b0;

    // Reset held with random inputs.
    repeat (5) begin
      @(negedge clock);
      bus.dmem_rw_addr = ($urandom_range(0, 1) == 1) ? DADDR : $urandom;
      bus.dmem_w_data  = $urandom;
      bus.dmem_w_en    = 1'($urandom_range(0, 1));
      mem_data         = $urandom;
      led_ovr          = $urandom;
      #1;
      check("reset_begin", {31'h0, bus.led_begin_flag}, 32'h0);
      check("reset_led_data", bus.led_in_data, 32'h0);
    end
    @(negedge clock);
    bus.dmem_rw_addr = SADDR;
    bus.dmem_w_en    = 1'b0;
    led_ovr          = '0;
    #1;
    check("reset_status", bus.cpu_r_data, 32'h0000_0002);
    led_ovr_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle_bus();

    // Single store, LED busy for 10 cycles.
    led_hold = 10;
    base     = n_begin;
    exp_q.push_back(32'h0000_00a5);
    store(DADDR, 32'h0000_00a5);
    idle_bus();
    wait_begins(base + 1, 10);
    if (begin_cyc.size() > base)
      check("begin_latency", 32'(begin_cyc[base] - last_store_cyc), 32'd2);
    repeat (3) @(negedge clock);
    read_stat("stat_while_busy", 1'b1, 0, 1'b0);
    wait_led_idle(30);
    repeat (2) @(negedge clock);
    read_stat("stat_after_done", 1'b0, 0, 1'b0);

    // Back-to-back stores 1..6 against a busy LED, then randomized bursts.
    overflow_round(6, 1'b1);
    repeat (3) overflow_round($urandom_range(1, 7), 1'b0);

    // LED never goes busy: each entry times out after TMO cycles in WAIT_START.
    led_hold = 0;
    base     = n_begin;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = $urandom;
      exp_q.push_back(d);
      store(DADDR, d);
    end
    idle_bus();
    wait_begins(base + 3, 60);
    if (begin_cyc.size() >= base + 3) begin
      check("timeout_gap_1", 32'(begin_cyc[base + 1] - begin_cyc[base]), 32'(TMO + 2));
      check("timeout_gap_2", 32'(begin_cyc[base + 2] - begin_cyc[base + 1]), 32'(TMO + 2));
    end
    repeat (10) @(negedge clock);
    read_stat("stat_after_timeouts", 1'b0, 0, 1'b0);

    // Address decode and load mux.
    @(negedge clock);
    bus.dmem_rw_addr = RAM_ADDR;
    bus.dmem_w_data  = $urandom;
    bus.dmem_w_en    = 1'b1;
    #1;
    check("mem_w_en_ram", {31'h0, bus.mem_w_en}, 32'h1);
    @(negedge clock);
    bus.dmem_rw_addr = SADDR;
    bus.dmem_w_en    = 1'b1;
    #1;
    check("mem_w_en_stat", {31'h0, bus.mem_w_en}, 32'h0);
    @(negedge clock);
    bus.dmem_rw_addr = RAM_ADDR;
    bus.dmem_w_en    = 1'b0;
    mem_data         = $urandom;
    #1;
    check("mem_w_en_load", {31'h0, bus.mem_w_en}, 32'h0);
    check("load_ram", bus.cpu_r_data, mem_data);
    @(negedge clock);
    bus.dmem_rw_addr = DADDR;
    mem_data         = $urandom;
    #1;
    check("load_led_data_addr", bus.cpu_r_data, mem_data);
    read_stat("load_stat", 1'b0, 0, 1'b0);

    // Reset asserted in WAIT_DONE with three entries queued.
    led_hold = 40;
    base     = n_begin;
    exp_q.push_back(32'hdead_0001);
    store(DADDR, 32'hdead_0001);
    idle_bus();
    wait_begins(base + 1, 10);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) store(DADDR, $urandom);
    read_stat("stat_before_reset", 1'b1, 3, 1'b0);
    @(negedge clock);
    exp_q.delete();
    reset_n          = 1'b0;
    bus.dmem_rw_addr = SADDR;
    bus.dmem_w_en    = 1'b0;
    #1;
    check("midreset_status", bus.cpu_r_data, stat_exp(1'b0, 0, 1'b0, led_busy));
    check("midreset_begin", {31'h0, bus.led_begin_flag}, 32'h0);
    check("midreset_led_data", bus.led_in_data, 32'h0);
    base = n_begin;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check("no_begin_after_reset", 32'(n_begin), 32'(base));
    read_stat("stat_after_reset", 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
